param_info_responder: RTL and testbench



---
 rtl/param_info_responder.sv | 216 +++++++++++++++++++++
 tb/tb_param_info_responder.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_info_responder.sv
// rtl/param_info_responder.sv - streams parameter name/value records on request; `PARAM_INFO_COUNT_EN adds query_count and entry 0xFE
module param_info_responder #(
  parameter bit SOME_BIT_PARAM = 1'b0,
  parameter int SOME_INT_PARAM = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_index,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_data,
  output logic        rsp_last,
  output logic        rsp_err
`ifdef PARAM_INFO_COUNT_EN
  ,
  output logic [15:0] query_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_NAME  = 3'd1,
    S_SEP   = 3'd2,
    S_VALUE = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  localparam logic [111:0] NAME_BIT  = "SOME_BIT_PARAM";
  localparam logic [111:0] NAME_INT  = "SOME_INT_PARAM";
  localparam logic [111:0] NAME_CNT  = "QUERY_COUNT___";
  localparam logic [3:0]   LAST_CHAR = 4'd13;

  state_t       state, state_n;
  logic [3:0]   char_cnt, char_cnt_n;
  logic [1:0]   byte_cnt, byte_cnt_n;
  logic [1:0]   entry, entry_n;
  logic [31:0]  value, value_n;
  logic [31:0]  query_value;
  logic [111:0] name_n;
  logic [1:0]   query_entry;
  logic         accept;
  logic         advance;
  logic         index_ok;

  logic         req_ready_d;
  logic         rsp_valid_d;
  logic [7:0]   rsp_data_d;
  logic         rsp_last_d;
  logic         rsp_err_d;

  assign accept  = req_valid && req_ready && (state == S_IDLE);
  assign advance = rsp_valid && rsp_ready;

`ifdef PARAM_INFO_COUNT_EN
  logic [15:0] count_q;
  assign query_count = count_q;
  assign index_ok    = (req_index < 8'd2) || (req_index == 8'hFE);
`else
  assign index_ok    = (req_index < 8'd2);
`endif

  // The value is snapshotted at acceptance so the count reports its pre-increment value.
  always_comb begin
    query_value = 32'd0;
    query_entry = 2'd2;
    case (req_index)
      8'd0: begin
        query_value = {31'd0, SOME_BIT_PARAM};
        query_entry = 2'd0;
      end
      8'd1: begin
        query_value = SOME_INT_PARAM;
        query_entry = 2'd1;
      end
      default: begin
`ifdef PARAM_INFO_COUNT_EN
        query_value = {16'd0, count_q};
`else
        query_value = 32'd0;
`endif
        query_entry = 2'd2;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      char_cnt  <= 4'd0;
      byte_cnt  <= 2'd0;
      entry     <= 2'd0;
      value     <= 32'd0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= 8'd0;
      rsp_last  <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_n;
      char_cnt  <= char_cnt_n;
      byte_cnt  <= byte_cnt_n;
      entry     <= entry_n;
      value     <= value_n;
      req_ready <= req_ready_d;
      rsp_valid <= rsp_valid_d;
      rsp_data  <= rsp_data_d;
      rsp_last  <= rsp_last_d;
      rsp_err   <= rsp_err_d;
    end
  end

`ifdef PARAM_INFO_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 16'd0;
    end else if (accept && (count_q != 16'hFFFF)) begin
      count_q <= count_q + 16'd1;
    end
  end
`endif

  always_comb begin
    state_n    = state;
    char_cnt_n = char_cnt;
    byte_cnt_n = byte_cnt;
    entry_n    = entry;
    value_n    = value;
    case (state)
      S_IDLE: begin
        if (accept) begin
          entry_n = query_entry;
          value_n = query_value;
          if (index_ok) begin
            state_n    = S_NAME;
            char_cnt_n = 4'd0;
          end else begin
            state_n = S_ERR;
          end
        end
      end
      S_NAME: begin
        if (advance) begin
          if (char_cnt == LAST_CHAR) begin
            state_n = S_SEP;
          end else begin
            char_cnt_n = char_cnt + 4'd1;
          end
        end
      end
      S_SEP: begin
        if (advance) begin
          state_n    = S_VALUE;
          byte_cnt_n = 2'd3;
        end
      end
      S_VALUE: begin
        if (advance) begin
          if (byte_cnt == 2'd0) begin
            state_n = S_IDLE;
          end else begin
            byte_cnt_n = byte_cnt - 2'd1;
          end
        end
      end
      S_ERR: begin
        if (advance) begin
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    case (entry_n)
      2'd0:    name_n = NAME_BIT;
      2'd1:    name_n = NAME_INT;
      default: name_n = NAME_CNT;
    endcase
  end

  // Output registers load from the next state, so a stall re-loads identical values.
  always_comb begin
    req_ready_d = (state_n == S_IDLE);
    rsp_valid_d = 1'b0;
    rsp_data_d  = 8'd0;
    rsp_last_d  = 1'b0;
    rsp_err_d   = 1'b0;
    case (state_n)
      S_NAME: begin
        rsp_valid_d = 1'b1;
        rsp_data_d  = name_n[{LAST_CHAR - char_cnt_n, 3'b000} +: 8];
      end
      S_SEP: begin
        rsp_valid_d = 1'b1;
      end
      S_VALUE: begin
        rsp_valid_d = 1'b1;
        rsp_data_d  = value_n[{byte_cnt_n, 3'b000} +: 8];
        rsp_last_d  = (byte_cnt_n == 2'd0);
      end
      S_ERR: begin
        rsp_valid_d = 1'b1;
        rsp_data_d  = 8'hFF;
        rsp_last_d  = 1'b1;
        rsp_err_d   = 1'b1;
      end
      default: begin
        rsp_valid_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_param_info_responder.sv
// tb/tb_param_info_responder.sv - directed bench for param_info_responder (also covers `PARAM_INFO_COUNT_EN builds)
module tb_param_info_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_index;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_data;
  logic        rsp_last;
  logic        rsp_err;
`ifdef PARAM_INFO_COUNT_EN
  logic [15:0] query_count;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0] cap_data [0:18];
  logic       cap_last [0:18];
  logic       cap_err  [0:18];
  int         cap_n;
  bit         held_ok;
  bit         gap_seen;
  bit         issue_timeout;

  always #5 clk = ~clk;

  param_info_responder #(
    .SOME_BIT_PARAM(1'b1),
    .SOME_INT_PARAM(-2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_index  (req_index),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_last   (rsp_last),
    .rsp_err    (rsp_err)
`ifdef PARAM_INFO_COUNT_EN
    ,
    .query_count(query_count)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] exp_byte(input string nm, input logic [31:0] v, input int i);
    if (i < 14) return nm[i];
    if (i == 14) return 8'h00;
    return v[8*(18-i) +: 8];
  endfunction

  // Presents one query; req_index is disturbed right after acceptance.
  task automatic issue(input logic [7:0] idx);
    int cyc;
    cyc = 0;
    while (req_ready !== 1'b1 && cyc < 50) begin
      step();
      cyc++;
    end
    issue_timeout = (cyc >= 50);
    req_valid = 1'b1;
    req_index = idx;
    step();
    req_valid = 1'b0;
    req_index = idx ^ 8'h01;
  endtask

  // Records n handshaken bytes; toggle drives rsp_ready 1,0,1,0...
  task automatic capture(input int n, input bit toggle);
    int cyc;
    bit phase, stalled;
    logic [7:0] pd;
    logic pl, pe;
    cyc = 0; phase = 1'b1; stalled = 1'b0;
    cap_n = 0; held_ok = 1'b1; gap_seen = 1'b0;
    pd = 8'h00; pl = 1'b0; pe = 1'b0;
    while (cap_n < n && cyc < 200) begin
      if (rsp_valid !== 1'b1) gap_seen = 1'b1;
      if (stalled && (rsp_valid !== 1'b1 || rsp_data !== pd || rsp_last !== pl || rsp_err !== pe))
        held_ok = 1'b0;
      rsp_ready = toggle ? phase : 1'b1;
      phase = ~phase;
      if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
        cap_data[cap_n] = rsp_data;
        cap_last[cap_n] = rsp_last;
        cap_err[cap_n]  = rsp_err;
        cap_n++;
        stalled = 1'b0;
      end else begin
        stalled = (rsp_valid === 1'b1);
        pd = rsp_data; pl = rsp_last; pe = rsp_err;
      end
      step();
      cyc++;
    end
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs got ready=%b valid=%b exp ready=0 valid=0", req_ready, rsp_valid);
    end
    checks++;
    if (rsp_data !== 8'h00 || rsp_last !== 1'b0 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_data got data=%h last=%b err=%b exp 00/0/0", rsp_data, rsp_last, rsp_err);
    end
    rst = 1'b0;
    rsp_ready = 1'b1;
    step();
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got ready=%b valid=%b exp ready=1 valid=0", req_ready, rsp_valid);
    end
    step();
    rsp_ready = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold got ready=%b valid=%b exp ready=1 valid=0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_bit_param();
    issue(8'd0);
    checks++;
    if (issue_timeout || rsp_valid !== 1'b1 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL bit_latency got timeout=%b valid=%b ready=%b exp 0/1/0", issue_timeout, rsp_valid, req_ready);
    end
    capture(19, 1'b0);
    checks++;
    if (cap_n != 19 || gap_seen) begin
      errors++;
      $display("FAIL bit_count got bytes=%0d gap=%b exp 19/0", cap_n, gap_seen);
    end
    for (int i = 0; i < 19; i++) begin
      checks++;
      if (cap_data[i] !== exp_byte("SOME_BIT_PARAM", 32'h0000_0001, i) || cap_last[i] !== (i == 18) || cap_err[i] !== 1'b0) begin
        errors++;
        $display("FAIL bit_byte%0d got %h/%b/%b exp %h/%b/0", i, cap_data[i], cap_last[i], cap_err[i],
                 exp_byte("SOME_BIT_PARAM", 32'h0000_0001, i), (i == 18));
      end
    end
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL bit_return got ready=%b valid=%b exp 1/0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_int_param_stall();
    issue(8'd1);
    checks++;
    if (issue_timeout || rsp_valid !== 1'b1 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL int_latency got timeout=%b valid=%b ready=%b exp 0/1/0", issue_timeout, rsp_valid, req_ready);
    end
    capture(19, 1'b1);
    checks++;
    if (cap_n != 19 || gap_seen || !held_ok) begin
      errors++;
      $display("FAIL int_stall got bytes=%0d gap=%b held=%b exp 19/0/1", cap_n, gap_seen, held_ok);
    end
    for (int i = 0; i < 19; i++) begin
      checks++;
      if (cap_data[i] !== exp_byte("SOME_INT_PARAM", 32'hFFFF_FFFE, i) || cap_last[i] !== (i == 18) || cap_err[i] !== 1'b0) begin
        errors++;
        $display("FAIL int_byte%0d got %h/%b/%b exp %h/%b/0", i, cap_data[i], cap_last[i], cap_err[i],
                 exp_byte("SOME_INT_PARAM", 32'hFFFF_FFFE, i), (i == 18));
      end
    end
  endtask

  task automatic test_bad_index();
    issue(8'd5);
    checks++;
    if (issue_timeout || rsp_valid !== 1'b1 || rsp_data !== 8'hFF || rsp_last !== 1'b1 || rsp_err !== 1'b1) begin
      errors++;
      $display("FAIL err_byte got valid=%b data=%h last=%b err=%b exp 1/ff/1/1", rsp_valid, rsp_data, rsp_last, rsp_err);
    end
    capture(1, 1'b0);
    checks++;
    if (cap_n != 1 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL err_return got bytes=%0d ready=%b valid=%b exp 1/1/0", cap_n, req_ready, rsp_valid);
    end
  endtask

  task automatic test_reset_mid_stream();
    issue(8'd0);
    capture(7, 1'b0);
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (cap_data[i] !== exp_byte("SOME_BIT_PARAM", 32'h0000_0001, i)) begin
        errors++;
        $display("FAIL abort_pre%0d got %h exp %h", i, cap_data[i], exp_byte("SOME_BIT_PARAM", 32'h0000_0001, i));
      end
    end
    rsp_ready = 1'b1;
    rst = 1'b1;
    step();
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort_reset got valid=%b ready=%b exp 0/0", rsp_valid, req_ready);
    end
    rst = 1'b0;
    step();
    step();
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_no_resume got valid=%b ready=%b exp 0/1", rsp_valid, req_ready);
    end
    issue(8'd1);
    capture(19, 1'b0);
    checks++;
    if (cap_n != 19 || gap_seen) begin
      errors++;
      $display("FAIL abort_after_count got bytes=%0d gap=%b exp 19/0", cap_n, gap_seen);
    end
    for (int i = 0; i < 19; i++) begin
      checks++;
      if (cap_data[i] !== exp_byte("SOME_INT_PARAM", 32'hFFFF_FFFE, i) || cap_last[i] !== (i == 18) || cap_err[i] !== 1'b0) begin
        errors++;
        $display("FAIL abort_after_byte%0d got %h/%b/%b exp %h/%b/0", i, cap_data[i], cap_last[i], cap_err[i],
                 exp_byte("SOME_INT_PARAM", 32'hFFFF_FFFE, i), (i == 18));
      end
    end
  endtask

`ifdef PARAM_INFO_COUNT_EN
  task automatic test_query_count();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    checks++;
    if (query_count !== 16'd0) begin
      errors++;
      $display("FAIL count_reset got %0d exp 0", query_count);
    end
    issue(8'd0);
    capture(19, 1'b0);
    issue(8'd1);
    capture(19, 1'b0);
    issue(8'd9);
    capture(1, 1'b0);
    checks++;
    if (query_count !== 16'd3 || cap_err[0] !== 1'b1) begin
      errors++;
      $display("FAIL count_three got count=%0d err=%b exp 3/1", query_count, cap_err[0]);
    end
    issue(8'hFE);
    capture(19, 1'b0);
    for (int i = 0; i < 19; i++) begin
      checks++;
      if (cap_data[i] !== exp_byte("QUERY_COUNT___", 32'h0000_0003, i) || cap_last[i] !== (i == 18) || cap_err[i] !== 1'b0) begin
        errors++;
        $display("FAIL count_byte%0d got %h/%b/%b exp %h/%b/0", i, cap_data[i], cap_last[i], cap_err[i],
                 exp_byte("QUERY_COUNT___", 32'h0000_0003, i), (i == 18));
      end
    end
    checks++;
    if (query_count !== 16'd4) begin
      errors++;
      $display("FAIL count_four got %0d exp 4", query_count);
    end
  endtask
`else
  task automatic test_fe_error();
    issue(8'hFE);
    checks++;
    if (issue_timeout || rsp_valid !== 1'b1 || rsp_data !== 8'hFF || rsp_last !== 1'b1 || rsp_err !== 1'b1) begin
      errors++;
      $display("FAIL fe_err got valid=%b data=%h last=%b err=%b exp 1/ff/1/1", rsp_valid, rsp_data, rsp_last, rsp_err);
    end
    capture(1, 1'b0);
    checks++;
    if (cap_n != 1 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL fe_return got bytes=%0d ready=%b exp 1/1", cap_n, req_ready);
    end
  endtask
`endif

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_index = 8'd0;
    rsp_ready = 1'b0;
    test_reset();
    test_bit_param();
    test_int_param_stall();
    test_bad_index();
    test_reset_mid_stream();
`ifdef PARAM_INFO_COUNT_EN
    test_query_count();
`else
    test_fe_error();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
